word_to_bitstream: RTL and testbench

WORD_TO_BITSTREAM -- requirements
Module: word_to_bitstream

---
 rtl/word_to_bitstream_pkg.sv | 18 +
 rtl/word_fifo.sv | 57 +++++
 rtl/word_to_bitstream.sv | 105 ++++++++++
 tb/tb_word_to_bitstream.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/word_to_bitstream_pkg.sv
// Shared types and legal parameter ranges for the word-to-bitstream serializer.
package word_to_bitstream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Word FIFO feeding the serializer; combinational head read, synchronous active-low reset.
module word_fifo
  import word_to_bitstream_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (!is_pow2(DEPTH) || DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
      $error("word_fifo: DEPTH must be a power of two in range");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/word_to_bitstream.sv
// Parallel-word to serial-bit converter: word_fifo in front of a two-state shift FSM.
//   state | meaning
//   IDLE  | shift register empty, data_out_valid=0, data_out=0
//   SHIFT | a word is being emitted one bit per data_out_ready edge
module word_to_bitstream
  import word_to_bitstream_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic             data_out,
  output logic             data_out_valid,
  input  logic             data_out_ready,
  output logic             frame_start,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("word_to_bitstream: WIDTH out of range");
    end
  endgenerate

  ser_state_t       state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             last_take;

  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign last_take     = (state == SHIFT) && data_out_ready && (bit_cnt == LAST);
  assign pop           = !fifo_empty && ((state == IDLE) || last_take);
  assign data_in_ready = !fifo_full || pop;
  assign push          = data_in_valid && data_in_ready;

  word_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (data_in),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (data_in_valid && !data_in_ready) overflow <= 1'b1;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shreg   <= fifo_head;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (data_out_ready) begin
            if (bit_cnt == LAST) begin
              bit_cnt <= '0;
              if (!fifo_empty) begin
                shreg <= fifo_head;
              end else begin
                shreg <= '0;
                state <= IDLE;
              end
            end else begin
              shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift register is zero in IDLE, so data_out reads 0 there.
  assign data_out       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign data_out_valid = (state == SHIFT);
  assign frame_start    = (state == SHIFT) && (bit_cnt == '0);

endmodule

// File: tb/tb_word_to_bitstream.sv
// Directed bench: MSB-first and LSB-first instances driven by a shared stimulus stream.
module tb_word_to_bitstream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_out_ready;

  logic m_in_ready, m_out, m_out_valid, m_frame, m_ovf;
  logic l_in_ready, l_out, l_out_valid, l_frame, l_ovf;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  word_to_bitstream #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (m_in_ready),
    .data_out       (m_out),
    .data_out_valid (m_out_valid),
    .data_out_ready (data_out_ready),
    .frame_start    (m_frame),
    .overflow       (m_ovf)
  );

  word_to_bitstream #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk            (clk),
    .rst_n          (rst_n),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_in_ready  (l_in_ready),
    .data_out       (l_out),
    .data_out_valid (l_out_valid),
    .data_out_ready (data_out_ready),
    .frame_start    (l_frame),
    .overflow       (l_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  logic [7:0]  w;
  logic [15:0] pair_msb;
  logic [15:0] pair_lsb;
  logic [7:0]  words [6];

  initial begin
    rst_n          = 1'b0;
    data_in        = '0;
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;
    step();
    step();
    chk("rst_out",       m_out, 1'b0);
    chk("rst_out_valid", m_out_valid, 1'b0);
    chk("rst_frame",     m_frame, 1'b0);
    chk("rst_overflow",  m_ovf, 1'b0);
    chk("rst_in_ready",  m_in_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // Single word 8'hAA, MSB first
    w             = 8'hAA;
    data_in       = w;
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
    chk("s1_not_yet_valid", m_out_valid, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("s1_valid", m_out_valid, 1'b1);
      chk("s1_bit",   m_out, w[7-i]);
      chk("s1_frame", m_frame, (i == 0));
      step();
    end
    chk("s1_idle_valid", m_out_valid, 1'b0);
    chk("s1_idle_out",   m_out, 1'b0);
    step();
    step();

    // Back-to-back 8'hAA, 8'h0F; LSB instance covers the LSB-first order
    pair_msb      = 16'b1010_1010_0000_1111;
    pair_lsb      = 16'b0101_0101_1111_0000;
    data_in       = 8'hAA;
    data_in_valid = 1'b1;
    step();
    data_in       = 8'h0F;
    step();
    data_in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("s2_valid",     m_out_valid, 1'b1);
      chk("s2_bit_msb",   m_out, pair_msb[15-i]);
      chk("s2_frame",     m_frame, (i == 0 || i == 8));
      chk("s2_bit_lsb",   l_out, pair_lsb[15-i]);
      chk("s2_frame_lsb", l_frame, (i == 0 || i == 8));
      step();
    end
    chk("s2_idle_valid", m_out_valid, 1'b0);
    chk("s2_idle_lsb",   l_out_valid, 1'b0);
    step();

    // Stall for 3 cycles while bit 3 of 8'hAA is presented
    w             = 8'hAA;
    data_in       = w;
    data_in_valid = 1'b1;
    step();
    data_in_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("s4_pre_bit", m_out, w[7-i]);
      step();
    end
    data_out_ready = 1'b0;
    chk("s4_bit3", m_out, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("s4_hold_bit",   m_out, 1'b0);
      chk("s4_hold_frame", m_frame, 1'b0);
      chk("s4_hold_valid", m_out_valid, 1'b1);
    end
    data_out_ready = 1'b1;
    for (int i = 3; i < 8; i++) begin
      chk("s4_post_bit", m_out, w[7-i]);
      step();
    end
    chk("s4_idle_valid", m_out_valid, 1'b0);
    step();

    // Capacity: 6 words offered with the sink stalled
    words[0] = 8'h81;
    words[1] = 8'h42;
    words[2] = 8'h24;
    words[3] = 8'h18;
    words[4] = 8'hC3;
    words[5] = 8'hFF;
    data_out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      data_in       = words[k];
      data_in_valid = 1'b1;
      chk("s5_in_ready", m_in_ready, (k < 5));
      step();
    end
    data_in_valid = 1'b0;
    chk("s5_overflow",     m_ovf, 1'b1);
    chk("s5_full_ready",   m_in_ready, 1'b0);
    chk("s5_shift_valid",  m_out_valid, 1'b1);
    chk("s5_shift_frame",  m_frame, 1'b1);
    data_out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w = words[k];
      for (int i = 0; i < 8; i++) begin
        chk("s5_drain_bit", m_out, w[7-i]);
        step();
      end
    end
    chk("s5_drop_idle", m_out_valid, 1'b0);
    chk("s5_ovf_sticky", m_ovf, 1'b1);
    step();

    // Reset during bit 4 of a word with two words queued
    data_out_ready = 1'b0;
    words[0] = 8'hB4;
    words[1] = 8'h5A;
    words[2] = 8'h3C;
    for (int k = 0; k < 3; k++) begin
      data_in       = words[k];
      data_in_valid = 1'b1;
      step();
    end
    data_in_valid  = 1'b0;
    data_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    w = words[0];
    chk("s6_bit4",        m_out, w[3]);
    chk("s6_ovf_before",  m_ovf, 1'b1);
    rst_n = 1'b0;
    step();
    chk("s6_rst_valid",    m_out_valid, 1'b0);
    chk("s6_rst_out",      m_out, 1'b0);
    chk("s6_rst_frame",    m_frame, 1'b0);
    chk("s6_rst_in_ready", m_in_ready, 1'b1);
    chk("s6_rst_overflow", m_ovf, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("s6_no_residue", m_out_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
